// File: rtl/exec_pkg.sv
// Shared definitions for the execution controller.
// Holds the controller state encodings and the width of the mode output.
package exec_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_STEP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FAST = 3'd3,
        ST_EDIT = 3'd4,
        ST_HALT = 3'd5
    } state_e;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a front-panel button level.
// The history register clears on reset, so a button held through reset produces one pulse afterwards.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic in_sig,
    output logic pulse
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = in_sig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign pulse = in_sig & ~hist_q;

endmodule

// File: rtl/exec_ctrl.sv
// Execution and program-load controller: CPU clock-enable pacing, ROM loading and step counting.
// Define BREAKPOINT_EN to add the pc/bp_addr/bp_valid inputs and the bp_hit output.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int CODE_W  = 32,
    parameter int RUN_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next,
    input  logic              run,
    input  logic              speed_run,
    input  logic              edit,
    input  logic [ADDR_W-1:0] line,
    input  logic [CODE_W-1:0] code,
    input  logic              send,
    input  logic              halt,
    output logic              cpu_en,
    output logic              cpu_rst,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [CODE_W-1:0] rom_wdata,
    output logic [MODE_W-1:0] mode,
    output logic [CNT_W-1:0]  step_cnt,
    output logic [ADDR_W:0]   load_cnt
`ifdef BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
    output logic              bp_hit
`endif
);

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [CODE_W-1:0] rom_wdata_q, rom_wdata_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
    logic [ADDR_W:0]   load_cnt_q, load_cnt_d;
    logic              next_edge, send_edge, bp_trip, run_tick, edit_entry;

    edge_pulse u_next_edge (.clk(clk), .rst(rst), .in_sig(next), .pulse(next_edge));
    edge_pulse u_send_edge (.clk(clk), .rst(rst), .in_sig(send), .pulse(send_edge));

`ifdef BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;
    assign bp_trip = bp_valid && (pc == bp_addr) && (state_q == ST_RUN || state_q == ST_FAST);
    assign bp_hit  = bp_hit_q;
`else
    assign bp_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            step_cnt_q  <= '0;
            load_cnt_q  <= '0;
`ifdef BREAKPOINT_EN
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            step_cnt_q  <= step_cnt_d;
            load_cnt_q  <= load_cnt_d;
`ifdef BREAKPOINT_EN
            bp_hit_q    <= bp_hit_d;
`endif
        end
    end

    // Priority: edit, then halt (HALT is sticky until edit or reset), then speed_run, run, next edge.
    always_comb begin
        state_d = state_q;
        if (edit) begin
            state_d = ST_EDIT;
        end else if (state_q == ST_EDIT) begin
            state_d = ST_IDLE;
        end else if (halt || bp_trip || state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (speed_run) begin
            state_d = ST_FAST;
        end else if (run) begin
            state_d = ST_RUN;
        end else if (next_edge) begin
            state_d = ST_STEP;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // The divider only advances while RUN persists, so every RUN entry restarts the pacing.
    always_comb begin
        run_tick   = (state_q == ST_RUN) && (state_d == ST_RUN) && (div_q == DIV_LAST);
        edit_entry = (state_d == ST_EDIT) && (state_q != ST_EDIT);

        div_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && div_q != DIV_LAST) begin
            div_d = div_q + DIV_W'(1);
        end

        cpu_en_d = !halt && ((state_d == ST_FAST) || (state_d == ST_STEP) || run_tick);

        step_cnt_d = step_cnt_q;
        if (cpu_en_d && step_cnt_q != '1) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end

        rom_we_d    = (state_q == ST_EDIT) && send_edge;
        rom_addr_d  = rom_we_d ? line : rom_addr_q;
        rom_wdata_d = rom_we_d ? code : rom_wdata_q;
        cpu_rst_d   = (state_q == ST_EDIT) && !edit;

        load_cnt_d = load_cnt_q;
        if (edit_entry) begin
            load_cnt_d = '0;
        end else if (rom_we_d && load_cnt_q != '1) begin
            load_cnt_d = load_cnt_q + (ADDR_W + 1)'(1);
        end

`ifdef BREAKPOINT_EN
        bp_hit_d = bp_hit_q;
        if (edit_entry) begin
            bp_hit_d = 1'b0;
        end else if (bp_trip) begin
            bp_hit_d = 1'b1;
        end
`endif
    end

    assign cpu_en    = cpu_en_q;
    assign cpu_rst   = cpu_rst_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign mode      = state_q;
    assign step_cnt  = step_cnt_q;
    assign load_cnt  = load_cnt_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Testbench for exec_ctrl: directed front-panel sequences with a pulse scoreboard.
// Expected cpu_en / rom_we / cpu_rst pulses are queued by the stimulus and popped by a negedge monitor.
module tb_exec_ctrl;

    localparam int ADDR_W = 8;
    localparam int CODE_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_STEP = 3'd1;
    localparam logic [2:0] M_RUN  = 3'd2;
    localparam logic [2:0] M_EDIT = 3'd4;
    localparam logic [2:0] M_HALT = 3'd5;

    logic              clk = 1'b0;
    logic              rst, next, run, speed_run, edit, send, halt;
    logic [ADDR_W-1:0] line;
    logic [CODE_W-1:0] code;
    logic              cpu_en, cpu_rst, rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [CODE_W-1:0] rom_wdata;
    logic [2:0]        mode;
    logic [CNT_W-1:0]  step_cnt;
    logic [ADDR_W:0]   load_cnt;
`ifdef BREAKPOINT_EN
    logic [ADDR_W-1:0] pc, bp_addr;
    logic              bp_valid, bp_hit;
`endif

    typedef struct {
        int               c;
        logic [ADDR_W-1:0] a;
        logic [CODE_W-1:0] d;
    } wr_t;

    int  en_q[$];
    int  rst_q[$];
    wr_t we_q[$];

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  exp_steps = 0;
    int  mon_c;
    wr_t mon_w;

    exec_ctrl #(.ADDR_W(ADDR_W), .CODE_W(CODE_W), .RUN_DIV(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .next(next), .run(run), .speed_run(speed_run), .edit(edit),
        .line(line), .code(code), .send(send), .halt(halt),
        .cpu_en(cpu_en), .cpu_rst(cpu_rst), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .mode(mode), .step_cnt(step_cnt), .load_cnt(load_cnt)
`ifdef BREAKPOINT_EN
        ,
        .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_en(input int c);
        en_q.push_back(c);
        exp_steps++;
    endtask

    task automatic push_we(input int c, input logic [ADDR_W-1:0] a, input logic [CODE_W-1:0] d);
        wr_t w;
        w.c = c;
        w.a = a;
        w.d = d;
        we_q.push_back(w);
    endtask

    // Monitor: every pulse the DUT presents must match the oldest queued expectation of its kind.
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            tests++;
            if (en_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL cpu_en: got unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_c = en_q.pop_front();
                if (mon_c != cyc) begin
                    fails++;
                    $display("[TB] FAIL cpu_en cycle: got %0d, expected %0d", cyc, mon_c);
                end
            end
        end
        if (rom_we === 1'b1) begin
            tests++;
            if (we_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL rom_we: got unexpected write at cycle %0d, expected none", cyc);
            end else begin
                mon_w = we_q.pop_front();
                if (mon_w.c != cyc || rom_addr !== mon_w.a || rom_wdata !== mon_w.d) begin
                    fails++;
                    $display("[TB] FAIL rom_we: got cyc %0d addr %0h data %0h, expected cyc %0d addr %0h data %0h",
                             cyc, rom_addr, rom_wdata, mon_w.c, mon_w.a, mon_w.d);
                end
            end
        end
        if (cpu_rst === 1'b1) begin
            tests++;
            if (rst_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL cpu_rst: got unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_c = rst_q.pop_front();
                if (mon_c != cyc) begin
                    fails++;
                    $display("[TB] FAIL cpu_rst cycle: got %0d, expected %0d", cyc, mon_c);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; next = 1'b0; run = 1'b0; speed_run = 1'b0; edit = 1'b0;
        send = 1'b0; halt = 1'b0; line = '0; code = '0;
`ifdef BREAKPOINT_EN
        pc = '0; bp_addr = 8'h10; bp_valid = 1'b0;
`endif
        tick(3);
        rst = 1'b0;
        check_output("reset mode", 32'(mode), 32'(M_IDLE));
        check_output("reset step_cnt", 32'(step_cnt), 0);
        check_output("reset load_cnt", 32'(load_cnt), 0);
        check_output("reset rom_addr", 32'(rom_addr), 0);
        check_output("reset rom_wdata", rom_wdata, 0);

        // Single step: next held three cycles gives one pulse.
        next = 1'b1;
        push_en(cyc + 1);
        tick(1);
        check_output("step mode", 32'(mode), 32'(M_STEP));
        tick(1);
        check_output("step back to idle", 32'(mode), 32'(M_IDLE));
        tick(1);
        next = 1'b0;
        tick(1);
        check_output("step count", 32'(step_cnt), 1);

        // RUN for 13 sampled cycles: pulses 4, 8, 12 cycles after entry.
        run = 1'b1;
        push_en(cyc + 5);
        push_en(cyc + 9);
        push_en(cyc + 13);
        tick(1);
        check_output("run mode", 32'(mode), 32'(M_RUN));
        tick(12);
        run = 1'b0;
        tick(2);
        check_output("run step_cnt", 32'(step_cnt), 4);
        check_output("run exit mode", 32'(mode), 32'(M_IDLE));

        // EDIT: one write, then a write coinciding with edit release.
        edit = 1'b1;
        tick(1);
        check_output("edit mode", 32'(mode), 32'(M_EDIT));
        line = 8'h05; code = 32'hDEADBEEF; send = 1'b1;
        push_we(cyc + 1, 8'h05, 32'hDEADBEEF);
        tick(1);
        send = 1'b0; line = 8'hAA; code = 32'h0;
        tick(1);
        check_output("load_cnt one", 32'(load_cnt), 1);
        check_output("rom_addr held", 32'(rom_addr), 32'h05);
        line = 8'h7F; code = 32'h12345678; send = 1'b1; edit = 1'b0;
        push_we(cyc + 1, 8'h7F, 32'h12345678);
        rst_q.push_back(cyc + 1);
        tick(1);
        check_output("edit exit mode", 32'(mode), 32'(M_IDLE));
        send = 1'b0;
        tick(1);
        check_output("load_cnt two", 32'(load_cnt), 2);
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(1);

        // FAST with halt after five pulses; HALT is sticky against run.
        speed_run = 1'b1;
        for (int k = 1; k <= 5; k++) push_en(cyc + k);
        tick(5);
        halt = 1'b1;
        tick(1);
        check_output("halt mode", 32'(mode), 32'(M_HALT));
        tick(4);
        speed_run = 1'b0; halt = 1'b0; run = 1'b1;
        tick(3);
        check_output("halt sticky", 32'(mode), 32'(M_HALT));
        check_output("halt step_cnt", 32'(step_cnt), 32'(exp_steps));
        run = 1'b0; edit = 1'b1;
        tick(1);
        check_output("halt to edit", 32'(mode), 32'(M_EDIT));
        check_output("load_cnt cleared", 32'(load_cnt), 0);
        edit = 1'b0;
        rst_q.push_back(cyc + 1);
        tick(1);
        check_output("edit release mode", 32'(mode), 32'(M_IDLE));

        // FAST interrupted by edit; then a send during reset is dropped.
        speed_run = 1'b1;
        for (int k = 1; k <= 3; k++) push_en(cyc + k);
        tick(3);
        edit = 1'b1;
        tick(1);
        check_output("fast to edit", 32'(mode), 32'(M_EDIT));
        check_output("no cpu_en in edit", 32'(cpu_en), 0);
        speed_run = 1'b0; rst = 1'b1; send = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_steps = 0;
        check_output("mid-edit reset mode", 32'(mode), 32'(M_IDLE));
        check_output("mid-edit reset step_cnt", 32'(step_cnt), 0);
        tick(1);
        check_output("edit after reset", 32'(mode), 32'(M_EDIT));
        check_output("no load after reset", 32'(load_cnt), 0);
        edit = 1'b0; send = 1'b0;
        rst_q.push_back(cyc + 1);
        tick(2);

        // Reset one cycle before a RUN pulse suppresses it; next held through reset steps once.
        run = 1'b1;
        tick(4);
        rst = 1'b1; run = 1'b0; next = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_steps = 0;
        check_output("mid-run reset mode", 32'(mode), 32'(M_IDLE));
        check_output("mid-run reset step_cnt", 32'(step_cnt), 0);
        push_en(cyc + 1);
        tick(1);
        check_output("held next steps", 32'(mode), 32'(M_STEP));
        next = 1'b0;
        tick(1);
        check_output("held next count", 32'(step_cnt), 1);

`ifdef BREAKPOINT_EN
        bp_valid = 1'b1; pc = 8'h0C; speed_run = 1'b1;
        for (int k = 1; k <= 3; k++) push_en(cyc + k);
        tick(1);
        pc = 8'h0E;
        tick(1);
        pc = 8'h0F;
        tick(1);
        pc = 8'h10;
        tick(1);
        check_output("bp halt mode", 32'(mode), 32'(M_HALT));
        check_output("bp_hit set", 32'(bp_hit), 1);
        speed_run = 1'b0; bp_valid = 1'b0;
        edit = 1'b1;
        tick(1);
        check_output("bp_hit cleared", 32'(bp_hit), 0);
`endif

        // Load 512 words: load_cnt saturates at 511.
        edit = 1'b1;
        tick(1);
        for (int i = 0; i < 512; i++) begin
            line = 8'(i);
            code = 32'(i) ^ 32'hA5A50000;
            send = 1'b1;
            push_we(cyc + 1, 8'(i), 32'(i) ^ 32'hA5A50000);
            tick(1);
            send = 1'b0;
            tick(1);
        end
        check_output("load_cnt saturated", 32'(load_cnt), 511);
        check_output("step_cnt final", 32'(step_cnt), 32'(exp_steps));
        edit = 1'b0;
        rst_q.push_back(cyc + 1);
        tick(3);

        check_output("cpu_en pulses missing", 32'(en_q.size()), 0);
        check_output("rom_we pulses missing", 32'(we_q.size()), 0);
        check_output("cpu_rst pulses missing", 32'(rst_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
